// File: rtl/jb_pkg.sv
// JOYBUS device shared definitions: command codes, response lengths, FSM states.
// Latency: n/a; backpressure: n/a.
package jb_pkg;

    localparam logic [7:0] JB_CMD_INFO  = 8'h00;
    localparam logic [7:0] JB_CMD_POLL  = 8'h01;
    localparam logic [7:0] JB_CMD_RESET = 8'hFF;

    localparam logic [5:0] JB_LEN_ID   = 6'd24;
    localparam logic [5:0] JB_LEN_POLL = 6'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_BIT,
        ST_RX_STOP,
        ST_RESP_WAIT,
        ST_TX_BIT,
        ST_TX_STOP
    } jb_state_t;

    function automatic logic jb_cmd_answers(input logic [7:0] cmd);
        return (cmd == JB_CMD_INFO) || (cmd == JB_CMD_POLL) || (cmd == JB_CMD_RESET);
    endfunction

endpackage

// File: rtl/jb_bit_tx.sv
// Single JOYBUS bit transmitter: 4 us cell, low 1 us for '1' or 3 us for '0'.
// Latency: oe asserts the cycle after start; done on the last cycle; no backpressure.
module jb_bit_tx #(
    parameter int CYC_PER_US = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_val,
    output logic oe,
    output logic done
);

    localparam int BIT_CYC = 4 * CYC_PER_US;
    localparam int CW      = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] LOW_ONE  = CW'(CYC_PER_US);
    localparam logic [CW-1:0] LOW_ZERO = CW'(3 * CYC_PER_US);

    logic          active;
    logic          bit_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] low_len;

    assign cnt_inc = cnt + CW'(1);
    assign low_len = bit_q ? LOW_ONE : LOW_ZERO;
    assign done    = active && (cnt == BIT_LAST);

    // start wins over done so back-to-back bits have no idle gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            bit_q  <= 1'b0;
            cnt    <= '0;
            oe     <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            bit_q  <= bit_val;
            cnt    <= '0;
            oe     <= 1'b1;
        end else if (active) begin
            if (cnt == BIT_LAST) begin
                active <= 1'b0;
                oe     <= 1'b0;
            end else begin
                cnt <= cnt_inc;
                oe  <= (cnt_inc < low_len);
            end
        end
    end

endmodule

// File: rtl/jb_device.sv
// JOYBUS responder emulating an N64 controller: decodes host command, answers identity or buttons.
// Latency: response starts RESP_DELAY_US after host stop; backpressure: none, bus is host-timed.
module jb_device
    import jb_pkg::*;
#(
    parameter int         CYC_PER_US    = 25,
    parameter int         RESP_DELAY_US = 2,
    parameter logic [7:0] ID_HI         = 8'h05,
    parameter logic [7:0] ID_LO         = 8'h00,
    parameter logic [7:0] ID_STAT       = 8'h02,
    parameter int         TIMEOUT_US    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jb_in,
    output logic        jb_oe,
    input  logic [31:0] btn_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        busy
);

    localparam int T1     = CYC_PER_US;
    localparam int TO_CYC = TIMEOUT_US * T1;
    localparam int CNT_W  = $clog2(TO_CYC + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(2 * T1);
    localparam logic [CNT_W-1:0] CNT_RESP = CNT_W'(RESP_DELAY_US * T1);
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(2 * T1);
    localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TO_CYC);

    jb_state_t        state, state_nxt;
    logic             jb_s1, jb_s2, jb_prev;
    logic             fall, rise, pulse_short, timeout, resp_poll;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       rx_sr;
    logic [31:0]      tx_sr;
    logic [5:0]       tx_left;
    logic             tx_start, tx_bit, tx_oe, tx_done, stop_oe;

    // Sync flops idle high so reset release never looks like a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            jb_s1   <= 1'b1;
            jb_s2   <= 1'b1;
            jb_prev <= 1'b1;
        end else begin
            jb_s1   <= jb_in;
            jb_s2   <= jb_s1;
            jb_prev <= jb_s2;
        end
    end

    assign fall        = jb_prev & ~jb_s2;
    assign rise        = ~jb_prev & jb_s2;
    assign pulse_short = (cnt < CNT_HALF);
    assign timeout     = (cnt > CNT_TO);
    assign resp_poll   = (cmd_byte == JB_CMD_POLL);
    assign busy        = (state != ST_IDLE);
    assign jb_oe       = tx_oe | stop_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        tx_bit    = 1'b0;
        case (state)
            ST_IDLE:    if (fall) state_nxt = ST_RX_BIT;
            ST_RX_BIT: begin
                if (timeout)                        state_nxt = ST_IDLE;
                else if (rise && bit_cnt == 4'd7)   state_nxt = ST_RX_STOP;
            end
            ST_RX_STOP: begin
                if (timeout)   state_nxt = ST_IDLE;
                else if (rise) state_nxt = (pulse_short && jb_cmd_answers(rx_sr)) ? ST_RESP_WAIT : ST_IDLE;
            end
            ST_RESP_WAIT: begin
                if (cnt == CNT_RESP) begin
                    state_nxt = ST_TX_BIT;
                    tx_start  = 1'b1;
                    tx_bit    = resp_poll ? btn_data[31] : ID_HI[7];
                end
            end
            ST_TX_BIT: begin
                if (tx_done) begin
                    if (tx_left == 6'd1) begin
                        state_nxt = ST_TX_STOP;
                    end else begin
                        tx_start = 1'b1;
                        tx_bit   = tx_sr[31];
                    end
                end
            end
            ST_TX_STOP: if (cnt == CNT_STOP) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // cnt measures level duration while receiving; it free-runs while responding so bus edges are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            tx_left   <= '0;
            stop_oe   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_byte  <= '0;
        end else begin
            cmd_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_RX_BIT, ST_RX_STOP: begin
                    if (fall || rise)    cnt <= CNT_ONE;
                    else if (cnt != '1)  cnt <= cnt + CNT_ONE;
                end
                ST_TX_BIT: cnt <= CNT_ONE;
                default:   cnt <= cnt + CNT_ONE;
            endcase
            if (state == ST_IDLE && fall)
                bit_cnt <= '0;
            if (state == ST_RX_BIT && rise && !timeout) begin
                rx_sr   <= {rx_sr[6:0], pulse_short};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (state == ST_RX_STOP && rise && !timeout && pulse_short) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= rx_sr;
            end
            // tx_sr holds the bits still to send after the one in flight
            if (state == ST_RESP_WAIT && tx_start) begin
                tx_sr   <= resp_poll ? {btn_data[30:0], 1'b0} : {ID_HI[6:0], ID_LO, ID_STAT, 9'h000};
                tx_left <= resp_poll ? JB_LEN_POLL : JB_LEN_ID;
            end
            if (state == ST_TX_BIT && tx_start) begin
                tx_sr   <= {tx_sr[30:0], 1'b0};
                tx_left <= tx_left - 6'd1;
            end
            if (state == ST_TX_BIT && state_nxt == ST_TX_STOP)
                stop_oe <= 1'b1;
            else if (state == ST_TX_STOP && state_nxt == ST_IDLE)
                stop_oe <= 1'b0;
        end
    end

    jb_bit_tx #(.CYC_PER_US(CYC_PER_US)) u_bit_tx (
        .clk     (clk),
        .rst     (rst),
        .start   (tx_start),
        .bit_val (tx_bit),
        .oe      (tx_oe),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_jb_device.sv
// Bench for jb_device: host-side bit driver, open-drain pad model, response decoder with scoreboard.
// Latency: n/a; backpressure: n/a.
module tb_jb_device;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_low;
    logic        jb_in;
    logic        jb_oe;
    logic [31:0] btn_data;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        busy;

    typedef struct {
        int          len;
        logic [31:0] data;
    } resp_t;

    logic [7:0] cmd_q[$];
    resp_t      resp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_cmd = 0;

    always #5 clk = ~clk;

    // open-drain bus: low if either side pulls
    assign jb_in = ~(jb_oe | host_low);

    jb_device dut (
        .clk       (clk),
        .rst       (rst),
        .jb_in     (jb_in),
        .jb_oe     (jb_oe),
        .btn_data  (btn_data),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) begin
            n_cmd++;
            if (cmd_q.size() == 0) chk("cmd_q_nonempty", 32'(cmd_q.size()), 32'd1);
            else                   chk("cmd_byte", 32'(cmd_byte), 32'(cmd_q.pop_front()));
        end
    end

    task automatic host_bit(input logic b);
        host_low = 1'b1;
        repeat (b ? 25 : 75) @(negedge clk);
        host_low = 1'b0;
        repeat (b ? 75 : 25) @(negedge clk);
    endtask

    task automatic host_stop();
        host_low = 1'b1;
        repeat (25) @(negedge clk);
        host_low = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        for (int i = 7; i >= 0; i--) host_bit(c[i]);
        host_stop();
    endtask

    // Decode a device reply from the pad, starting at the host stop release
    task automatic rx_resp(input int nbits);
        logic [31:0] data  = '0;
        int          gap   = 0;
        int          low   = 0;
        int          high  = 0;
        int          stop  = 0;
        int          bad_w = 0;
        int          bad_p = 0;
        resp_t       e;
        while (!jb_oe && gap < 400) begin @(negedge clk); gap++; end
        chk("resp_gap_2us", 32'(gap >= 50 && gap <= 56), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            low = 0;
            while (jb_oe && low < 300) begin @(negedge clk); low++; end
            high = 0;
            while (!jb_oe && high < 300) begin @(negedge clk); high++; end
            data = {data[30:0], (low < 50) ? 1'b1 : 1'b0};
            if (!(low == 25 || low == 75)) bad_w++;
            if (low + high != 100) bad_p++;
        end
        while (jb_oe && stop < 300) begin @(negedge clk); stop++; end
        chk("bit_low_width", 32'(bad_w), 32'd0);
        chk("bit_period", 32'(bad_p), 32'd0);
        chk("tx_stop_width", 32'(stop), 32'd50);
        if (resp_q.size() == 0) begin
            chk("resp_q_nonempty", 32'(resp_q.size()), 32'd1);
        end else begin
            e = resp_q.pop_front();
            chk("resp_len", 32'(nbits), 32'(e.len));
            chk("resp_data", data, e.data);
        end
        repeat (2) @(negedge clk);
        chk("busy_after_resp", 32'(busy), 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int    saw;
        int    n;
        int    n_before;
        resp_t r;

        rst      = 1'b1;
        host_low = 1'b0;
        btn_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_jb_oe", 32'(jb_oe), 32'd0);
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_cmd_byte", 32'(cmd_byte), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // poll with A pressed
        btn_data = 32'hA000_0000;
        cmd_q.push_back(8'h01);
        r.len = 32; r.data = 32'hA000_0000; resp_q.push_back(r);
        send_cmd(8'h01);
        rx_resp(32);

        // info and reset both answer identity
        cmd_q.push_back(8'h00);
        r.len = 24; r.data = 32'h0005_0002; resp_q.push_back(r);
        send_cmd(8'h00);
        rx_resp(24);

        cmd_q.push_back(8'hFF);
        r.len = 24; r.data = 32'h0005_0002; resp_q.push_back(r);
        send_cmd(8'hFF);
        rx_resp(24);

        // truncated frame then idle-high timeout
        n_before = n_cmd;
        @(negedge clk);
        host_bit(1'b1); host_bit(1'b0); host_bit(1'b1); host_bit(1'b1); host_bit(1'b0);
        repeat (140) @(negedge clk);
        chk("to_busy_before", 32'(busy), 32'd1);
        repeat (60) @(negedge clk);
        chk("to_busy_after", 32'(busy), 32'd0);
        chk("to_jb_oe", 32'(jb_oe), 32'd0);
        chk("to_no_cmd_valid", 32'(n_cmd), 32'(n_before));

        // unsupported command: reported but not answered
        cmd_q.push_back(8'h42);
        send_cmd(8'h42);
        @(negedge clk);
        chk("c42_busy_at_rise", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        chk("c42_busy_idle", 32'(busy), 32'd0);
        saw = 0;
        repeat (150) begin @(negedge clk); if (jb_oe) saw = 1; end
        chk("c42_no_resp", 32'(saw), 32'd0);

        // async reset in the middle of a low phase
        btn_data = 32'hFFFF_FFFF;
        cmd_q.push_back(8'h01);
        send_cmd(8'h01);
        n = 0;
        while (!jb_oe && n < 200) begin @(negedge clk); n++; end
        repeat (130) @(negedge clk);
        n = 0;
        while (!jb_oe && n < 200) begin @(negedge clk); n++; end
        chk("mid_tx_oe_high", 32'(jb_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_jb_oe", 32'(jb_oe), 32'd0);
        chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("arst_cmd_byte", 32'(cmd_byte), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        btn_data = 32'hA5C3_0F1E;
        cmd_q.push_back(8'h01);
        r.len = 32; r.data = 32'hA5C3_0F1E; resp_q.push_back(r);
        send_cmd(8'h01);
        rx_resp(32);

        // buttons change mid-frame; the frame keeps the sampled word
        btn_data = 32'hFFFF_FFFF;
        cmd_q.push_back(8'h01);
        r.len = 32; r.data = 32'hFFFF_FFFF; resp_q.push_back(r);
        send_cmd(8'h01);
        fork
            rx_resp(32);
            begin repeat (400) @(negedge clk); btn_data = 32'h0; end
        join

        repeat (5) @(negedge clk);
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
        chk("cmd_valid_count", 32'(n_cmd), 32'd7);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
